// File: rtl/sync_fifo_ctrl_if.sv
// Bundle of the FIFO handshake signals and the dual-port RAM drive signals.
// slave  : the FIFO controller's view.
// master : the surrounding logic's view (producer, consumer and RAM).
interface sync_fifo_ctrl_if #(
  parameter int WIDTH    = 8,
  parameter int ADDR_BUS = 6
);
  // Producer side
  logic                wr_en;
  logic [WIDTH-1:0]    wr_data;
  logic                full;
  // Consumer side
  logic                rd_en;
  logic [WIDTH-1:0]    rd_data;
  logic                rd_valid;
  logic                empty;
  // Status
  logic [ADDR_BUS:0]   count;
  logic                overflow;
  logic                underflow;
  // RAM port 1 (write)
  logic                ram_we_1;
  logic [ADDR_BUS-1:0] ram_addr_1;
  logic [WIDTH-1:0]    ram_din_1;
  // RAM port 2 (read)
  logic                ram_we_2;
  logic [ADDR_BUS-1:0] ram_addr_2;
  logic [WIDTH-1:0]    ram_din_2;
  logic [WIDTH-1:0]    ram_dout_2;

  modport slave (
    input  wr_en, wr_data, rd_en, ram_dout_2,
    output full, rd_data, rd_valid, empty, count, overflow, underflow,
           ram_we_1, ram_addr_1, ram_din_1, ram_we_2, ram_addr_2, ram_din_2
  );

  modport master (
    output wr_en, wr_data, rd_en, ram_dout_2,
    input  full, rd_data, rd_valid, empty, count, overflow, underflow,
           ram_we_1, ram_addr_1, ram_din_1, ram_we_2, ram_addr_2, ram_din_2
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller around an external dual-port synchronous RAM.
// Owns the read/write pointers, occupancy count, full/empty flags and the
// overflow/underflow pulses; the RAM holds the data and registers its read
// output on the same edge that advances the read pointer.
module sync_fifo_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int ADDR_BUS = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,   // synchronous, active-low
  sync_fifo_ctrl_if.slave    bus
);

  localparam logic [ADDR_BUS:0] C_DEPTH = (ADDR_BUS+1)'(DEPTH);

  logic [ADDR_BUS-1:0] r_wptr;
  logic [ADDR_BUS-1:0] r_rptr;
  logic [ADDR_BUS:0]   r_count;
  logic                r_full;
  logic                r_empty;
  logic                r_rd_valid;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_push;
  logic                w_pop;
  logic [ADDR_BUS:0]   w_count_next;

  // Accept decisions use the registered flags; nothing is accepted in reset.
  assign w_push = rst && bus.wr_en && !r_full;
  assign w_pop  = rst && bus.rd_en && !r_empty;

  // RAM drive: port 1 writes at the write pointer, port 2 reads at the read pointer.
  assign bus.ram_we_1   = w_push;
  assign bus.ram_addr_1 = r_wptr;
  assign bus.ram_din_1  = bus.wr_data;
  assign bus.ram_we_2   = 1'b0;
  assign bus.ram_addr_2 = r_rptr;
  assign bus.ram_din_2  = {WIDTH{1'b0}};

  // Status outputs; read data comes straight from the RAM's output register.
  assign bus.rd_data   = bus.ram_dout_2;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.full      = r_full;
  assign bus.empty     = r_empty;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

  // Next occupancy: +1 for push alone, -1 for pop alone, else unchanged.
  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no latch is inferred.
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Pointer, count and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count     <= w_count_next;
      r_full      <= (w_count_next == C_DEPTH);
      r_empty     <= (w_count_next == '0);
      r_rd_valid  <= w_pop;
      r_overflow  <= bus.wr_en && r_full;
      r_underflow <= bus.rd_en && r_empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: directed stimulus with literal expectations,
// a queue-based reference model compared on every falling edge, and a
// behavioural dual-port RAM with registered read.
module tb_sync_fifo_ctrl;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 64;
  localparam int ADDR_BUS = 6;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  sync_fifo_ctrl_if #(.WIDTH(WIDTH), .ADDR_BUS(ADDR_BUS)) bus ();

  sync_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BUS(ADDR_BUS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: port-1 write, port-2 registered read.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we_1) mem[bus.ram_addr_1] <= bus.ram_din_1;
    bus.ram_dout_2 <= mem[bus.ram_addr_2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_q[$];
  bit               m_started;
  bit               m_ov, m_un, m_rv;
  logic [WIDTH-1:0] m_rd_data;
  int               m_pushes, m_pops;

  always @(posedge clk) begin
    bit do_push, do_pop;
    m_started = 1'b1;
    if (!rst) begin
      m_q.delete();
      m_ov = 0; m_un = 0; m_rv = 0;
      m_pushes = 0; m_pops = 0;
    end else begin
      do_push = bus.wr_en && (m_q.size() < DEPTH);
      do_pop  = bus.rd_en && (m_q.size() > 0);
      m_ov = bus.wr_en && (m_q.size() == DEPTH);
      m_un = bus.rd_en && (m_q.size() == 0);
      m_rv = do_pop;
      if (do_pop) begin
        m_rd_data = m_q.pop_front();
        m_pops++;
      end
      if (do_push) begin
        m_q.push_back(bus.wr_data);
        m_pushes++;
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (m_started) begin
      check("m_count",     32'(bus.count),     32'(m_q.size()));
      check("m_full",      32'(bus.full),      32'(m_q.size() == DEPTH));
      check("m_empty",     32'(bus.empty),     32'(m_q.size() == 0));
      check("m_overflow",  32'(bus.overflow),  32'(m_ov));
      check("m_underflow", 32'(bus.underflow), 32'(m_un));
      check("m_rd_valid",  32'(bus.rd_valid),  32'(m_rv));
      if (m_rv) check("m_rd_data", 32'(bus.rd_data), 32'(m_rd_data));
      check("m_ram_we_1",  32'(bus.ram_we_1),
            32'(rst && bus.wr_en && (m_q.size() < DEPTH)));
      check("m_ram_addr_1", 32'(bus.ram_addr_1), 32'(m_pushes % DEPTH));
      check("m_ram_din_1",  32'(bus.ram_din_1),  32'(bus.wr_data));
      check("m_ram_addr_2", 32'(bus.ram_addr_2), 32'(m_pops % DEPTH));
      check("m_ram_we_2",   32'(bus.ram_we_2),   32'(0));
      check("m_ram_din_2",  32'(bus.ram_din_2),  32'(0));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [WIDTH-1:0] exp);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check({name, "_rv"}, 32'(bus.rd_valid), 32'(1));
    check({name, "_data"}, 32'(bus.rd_data), 32'(exp));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    // Reset with push/pop requests active: nothing may be accepted.
    rst         = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hAA;
    bus.rd_en   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_empty",    32'(bus.empty),    32'(1));
      check("rst_full",     32'(bus.full),     32'(0));
      check("rst_count",    32'(bus.count),    32'(0));
      check("rst_rd_valid", 32'(bus.rd_valid), 32'(0));
      check("rst_we_1",     32'(bus.ram_we_1), 32'(0));
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    rst       = 1'b1;
    step();

    // Single word.
    push(8'h11);
    check("single_count1", 32'(bus.count), 32'(1));
    check("single_empty0", 32'(bus.empty), 32'(0));
    pop_expect("single_pop", 8'h11);
    check("single_count0", 32'(bus.count), 32'(0));
    step();
    check("single_rv_drop", 32'(bus.rd_valid), 32'(0));

    // Fill and overflow.
    for (int i = 0; i < 64; i++) push(8'(i));
    check("fill_full",  32'(bus.full),  32'(1));
    check("fill_count", 32'(bus.count), 32'(64));
    push(8'hFF);
    check("ovf_pulse", 32'(bus.overflow), 32'(1));
    check("ovf_count", 32'(bus.count),    32'(64));
    step();
    check("ovf_once",  32'(bus.overflow), 32'(0));
    for (int i = 0; i < 64; i++) pop_expect("drain", 8'(i));
    step();
    check("drain_empty", 32'(bus.empty), 32'(1));

    // Underflow: three rejected pops.
    bus.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("unf_pulse", 32'(bus.underflow), 32'(1));
      check("unf_rv",    32'(bus.rd_valid),  32'(0));
      check("unf_count", 32'(bus.count),     32'(0));
    end
    bus.rd_en = 1'b0;
    step();
    check("unf_clear", 32'(bus.underflow), 32'(0));

    // Wrap-around: 65 pushes so far, so pointers start at 1.
    for (int i = 0; i < 40; i++) push(8'h40 + 8'(i));
    for (int i = 0; i < 40; i++) pop_expect("wrap_a", 8'h40 + 8'(i));
    for (int i = 0; i < 40; i++) begin
      if (i == 22) check("wrap_addr63", 32'(bus.ram_addr_1), 32'(63));
      if (i == 23) check("wrap_addr0",  32'(bus.ram_addr_1), 32'(0));
      push(8'h80 + 8'(i));
    end
    for (int i = 0; i < 40; i++) pop_expect("wrap_b", 8'h80 + 8'(i));
    step();
    check("wrap_empty", 32'(bus.empty), 32'(1));

    // Simultaneous push/pop at count 5.
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      bus.wr_en   = 1'b1;
      bus.rd_en   = 1'b1;
      bus.wr_data = 8'hD0 + 8'(i);
      step();
      check("sim_count", 32'(bus.count), 32'(5));
      check("sim_data",  32'(bus.rd_data),
            (i < 5) ? 32'(8'hC0 + 8'(i)) : 32'(8'hD0 + 8'(i - 5)));
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    for (int i = 5; i < 10; i++) pop_expect("sim_tail", 8'hD0 + 8'(i));

    // Simultaneous at full: pop wins, push rejected.
    for (int i = 0; i < 64; i++) push(8'h20 + 8'(i));
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.wr_data = 8'hEE;
    step();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("full_both_ovf",   32'(bus.overflow), 32'(1));
    check("full_both_count", 32'(bus.count),    32'(63));
    check("full_both_rv",    32'(bus.rd_valid), 32'(1));
    check("full_both_data",  32'(bus.rd_data),  32'(8'h20));
    check("full_both_full",  32'(bus.full),     32'(0));
    for (int i = 1; i < 64; i++) pop_expect("full_drain", 8'h20 + 8'(i));

    // Simultaneous at empty: push wins, pop rejected, no fall-through.
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.wr_data = 8'h5A;
    step();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("empty_both_unf",   32'(bus.underflow), 32'(1));
    check("empty_both_count", 32'(bus.count),     32'(1));
    check("empty_both_rv",    32'(bus.rd_valid),  32'(0));
    check("empty_both_empty", 32'(bus.empty),     32'(0));
    pop_expect("empty_both_pop", 8'h5A);

    // Reset mid-burst discards stored data.
    for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
    rst = 1'b0;
    step();
    check("midrst_count", 32'(bus.count), 32'(0));
    check("midrst_empty", 32'(bus.empty), 32'(1));
    rst = 1'b1;
    step();
    push(8'h99);
    pop_expect("post_rst", 8'h99);

    step();
    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
